// File: rtl/exe_mem_pipe_reg.sv
// exe_mem_pipe_reg: elastic EX->MEM pipeline register with STAGES valid-tagged slots.
// Carries ALU result, store data, destination and MEM/WB enables.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     kill all in-flight entries
//   in_valid / in_ready       EXE-side handshake
//   mem_w_en_in, mem_r_en_in, wb_en_in, alu_res_in, val_rm_in, dest_in   entry fields
//   out_valid / out_ready     MEM-side handshake (head slot)
//   mem_w_en_out, mem_r_en_out, wb_en_out   head enables, gated by out_valid
//   alu_res_out, val_rm_out, dest_out       head data (stale when out_valid=0)
//   src1, src2 / hazard       RAW check against live write-back slots
//   occupancy                 number of live slots
module exe_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int STAGES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         mem_w_en_in,
    input  logic                         mem_r_en_in,
    input  logic                         wb_en_in,
    input  logic [DATA_W-1:0]            alu_res_in,
    input  logic [DATA_W-1:0]            val_rm_in,
    input  logic [DEST_W-1:0]            dest_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         mem_w_en_out,
    output logic                         mem_r_en_out,
    output logic                         wb_en_out,
    output logic [DATA_W-1:0]            alu_res_out,
    output logic [DATA_W-1:0]            val_rm_out,
    output logic [DEST_W-1:0]            dest_out,
    input  logic [DEST_W-1:0]            src1,
    input  logic [DEST_W-1:0]            src2,
    output logic                         hazard,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int HEAD  = STAGES - 1;
    localparam int OCC_W = $clog2(STAGES + 1);

    // Slot storage; index 0 is the tail, HEAD drives the outputs.
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] mw;
    logic [STAGES-1:0] mr;
    logic [STAGES-1:0] wb;
    logic [DATA_W-1:0] alu_q  [STAGES];
    logic [DATA_W-1:0] rm_q   [STAGES];
    logic [DEST_W-1:0] dest_q [STAGES];
    logic [OCC_W-1:0]  occ_q;

    logic [STAGES-1:0] move;
    logic              head_go;
    logic              accept;

    // Per-slot "moves this cycle" chain, built head-first. Each slot gets
    // its own scope so the ripple is not a self-referencing vector.
    for (genvar i = 0; i < STAGES; i++) begin : g_mv
        logic mv;
        if (i == HEAD) begin : g_head
            assign mv = v[i] && out_ready;
        end else begin : g_body
            assign mv = v[i] && (!v[i+1] || g_mv[i+1].mv);
        end
        assign move[i] = mv;
    end

    assign head_go  = move[HEAD];
    assign in_ready = !flush && (!v[0] || move[0]);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            v     <= '0;
            mw    <= '0;
            mr    <= '0;
            wb    <= '0;
            occ_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                alu_q[i]  <= '0;
                rm_q[i]   <= '0;
                dest_q[i] <= '0;
            end
        end else if (flush) begin
            // Data fields deliberately keep their values; only the
            // valid tags and control bits die.
            v     <= '0;
            mw    <= '0;
            mr    <= '0;
            wb    <= '0;
            occ_q <= '0;
        end else begin
            if (accept) begin
                v[0]      <= 1'b1;
                mw[0]     <= mem_w_en_in;
                mr[0]     <= mem_r_en_in;
                wb[0]     <= wb_en_in;
                alu_q[0]  <= alu_res_in;
                rm_q[0]   <= val_rm_in;
                dest_q[0] <= dest_in;
            end else if (move[0]) begin
                v[0] <= 1'b0;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (move[i-1]) begin
                    v[i]      <= 1'b1;
                    mw[i]     <= mw[i-1];
                    mr[i]     <= mr[i-1];
                    wb[i]     <= wb[i-1];
                    alu_q[i]  <= alu_q[i-1];
                    rm_q[i]   <= rm_q[i-1];
                    dest_q[i] <= dest_q[i-1];
                end else if (move[i]) begin
                    v[i] <= 1'b0;
                end
            end
            occ_q <= occ_q + OCC_W'(accept) - OCC_W'(head_go);
        end
    end

    assign out_valid    = v[HEAD];
    assign mem_w_en_out = mw[HEAD] && v[HEAD];
    assign mem_r_en_out = mr[HEAD] && v[HEAD];
    assign wb_en_out    = wb[HEAD] && v[HEAD];
    assign alu_res_out  = alu_q[HEAD];
    assign val_rm_out   = rm_q[HEAD];
    assign dest_out     = dest_q[HEAD];
    assign occupancy    = occ_q;

    // Flush is intentionally not used here: the hazard only clears
    // once the flush edge has dropped the valid tags.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (v[i] && wb[i] &&
                (dest_q[i] == src1 || dest_q[i] == src2)) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// tb_exe_mem_pipe_reg: directed checks of exe_mem_pipe_reg
// at STAGES=1, 2 and 3 driven from shared inputs.
module tb_exe_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        mw_in, mr_in, wb_in;
    logic [31:0] alu_in, rm_in;
    logic [3:0]  dest_in, src1, src2;

    logic        ir1, ov1, mw1, mr1, wb1, hz1;
    logic [31:0] alu1, rm1;
    logic [3:0]  d1;
    logic [0:0]  occ1;

    logic        ir2, ov2, mw2, mr2, wb2, hz2;
    logic [31:0] alu2, rm2;
    logic [3:0]  d2;
    logic [1:0]  occ2;

    logic        ir3, ov3, mw3, mr3, wb3, hz3;
    logic [31:0] alu3, rm3;
    logic [3:0]  d3;
    logic [1:0]  occ3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(4), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1),
        .mem_w_en_in(mw_in), .mem_r_en_in(mr_in), .wb_en_in(wb_in),
        .alu_res_in(alu_in), .val_rm_in(rm_in), .dest_in(dest_in),
        .out_valid(ov1), .out_ready(out_ready),
        .mem_w_en_out(mw1), .mem_r_en_out(mr1), .wb_en_out(wb1),
        .alu_res_out(alu1), .val_rm_out(rm1), .dest_out(d1),
        .src1(src1), .src2(src2), .hazard(hz1), .occupancy(occ1)
    );

    exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(4), .STAGES(2)) u2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir2),
        .mem_w_en_in(mw_in), .mem_r_en_in(mr_in), .wb_en_in(wb_in),
        .alu_res_in(alu_in), .val_rm_in(rm_in), .dest_in(dest_in),
        .out_valid(ov2), .out_ready(out_ready),
        .mem_w_en_out(mw2), .mem_r_en_out(mr2), .wb_en_out(wb2),
        .alu_res_out(alu2), .val_rm_out(rm2), .dest_out(d2),
        .src1(src1), .src2(src2), .hazard(hz2), .occupancy(occ2)
    );

    exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(4), .STAGES(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir3),
        .mem_w_en_in(mw_in), .mem_r_en_in(mr_in), .wb_en_in(wb_in),
        .alu_res_in(alu_in), .val_rm_in(rm_in), .dest_in(dest_in),
        .out_valid(ov3), .out_ready(out_ready),
        .mem_w_en_out(mw3), .mem_r_en_out(mr3), .wb_en_out(wb3),
        .alu_res_out(alu3), .val_rm_out(rm3), .dest_out(d3),
        .src1(src1), .src2(src2), .hazard(hz3), .occupancy(occ3)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 1;
        mw_in = 0; mr_in = 0; wb_in = 0;
        alu_in = '0; rm_in = '0; dest_in = '0; src1 = '0; src2 = '0;
        tick; tick;

        // 1: reset state
        rst = 0; #1;
        chk("t1 ov2", ov2, 0);   chk("t1 ov3", ov3, 0);
        chk("t1 mw3", mw3, 0);   chk("t1 mr3", mr3, 0);
        chk("t1 wb3", wb3, 0);   chk("t1 alu3", alu3, 0);
        chk("t1 rm3", rm3, 0);   chk("t1 d3", d3, 0);
        chk("t1 occ3", occ3, 0); chk("t1 hz3", hz3, 0);
        chk("t1 ir3", ir3, 1);   chk("t1 ir2", ir2, 1);
        chk("t1 occ1", occ1, 0); chk("t1 ov1", ov1, 0);
        tick;

        // 2: back-to-back stream, STAGES=3 and STAGES=1
        out_ready = 1;
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 5);
            alu_in = 32'h10 + c;
            rm_in = 32'hA000 + c;
            #1;
            if (c < 5) chk("t2 ir3", ir3, 1);
            if (c >= 3 && c <= 7) begin
                chk("t2 ov3", ov3, 1);
                chk("t2 alu3", alu3, 32'h10 + c - 3);
                chk("t2 rm3", rm3, 32'hA000 + c - 3);
            end else begin
                chk("t2 ov3 idle", ov3, 0);
            end
            if (c >= 1 && c <= 5) begin
                chk("t2 ov1", ov1, 1);
                chk("t2 alu1", alu1, 32'h10 + c - 1);
            end else begin
                chk("t2 ov1 idle", ov1, 0);
            end
            tick;
        end

        // 3: stall, STAGES=2
        out_ready = 0; in_valid = 1; alu_in = 32'h20; #1;
        chk("t3 ir a", ir2, 1);
        tick;
        alu_in = 32'h21; #1;
        chk("t3 ir b", ir2, 1);
        chk("t3 ov empty", ov2, 0);
        tick;
        alu_in = 32'h22; #1;
        chk("t3 ir full", ir2, 0);
        chk("t3 occ full", occ2, 2);
        chk("t3 head a", alu2, 32'h20);
        tick;
        #1;
        chk("t3 head hold", alu2, 32'h20);
        chk("t3 occ hold", occ2, 2);
        out_ready = 1; #1;
        chk("t3 ir release", ir2, 1);
        tick;
        in_valid = 0; #1;
        chk("t3 ov b", ov2, 1);
        chk("t3 head b", alu2, 32'h21);
        tick;
        chk("t3 head c", alu2, 32'h22);
        chk("t3 occ c", occ2, 1);
        tick;
        chk("t3 ov done", ov2, 0);
        chk("t3 occ done", occ2, 0);
        tick; tick; tick;
        chk("t3 occ3 drained", occ3, 0);

        // 4: flush while full, STAGES=2
        out_ready = 0; wb_in = 1; dest_in = 4'd5; src1 = 4'd5; src2 = 4'd0;
        in_valid = 1; alu_in = 32'h30;
        tick;
        alu_in = 32'h31;
        tick;
        flush = 1; #1;
        chk("t4 ir flush", ir2, 0);
        chk("t4 occ pre", occ2, 2);
        chk("t4 hz pre", hz2, 1);
        tick;
        flush = 0; in_valid = 0; #1;
        chk("t4 ov", ov2, 0);
        chk("t4 wb", wb2, 0);
        chk("t4 occ", occ2, 0);
        chk("t4 hz", hz2, 0);
        chk("t4 stale alu", alu2, 32'h30);
        chk("t4 occ3", occ3, 0);

        // 5: hazard, STAGES=2
        dest_in = 4'd7; wb_in = 1; in_valid = 1; alu_in = 32'h40;
        tick;
        in_valid = 0; src1 = 4'd7; src2 = 4'd0; #1;
        chk("t5 hz tail", hz2, 1);
        src1 = 4'd3; src2 = 4'd3; #1;
        chk("t5 hz none", hz2, 0);
        src2 = 4'd7; #1;
        chk("t5 hz src2", hz2, 1);
        tick;
        src1 = 4'd7; src2 = 4'd0; #1;
        chk("t5 hz head", hz2, 1);
        chk("t5 wb head", wb2, 1);
        chk("t5 dest head", d2, 7);
        flush = 1;
        tick;
        flush = 0; wb_in = 0; in_valid = 1; alu_in = 32'h41;
        tick;
        in_valid = 0; #1;
        chk("t5 occ nowb", occ2, 1);
        chk("t5 hz nowb tail", hz2, 0);
        tick;
        chk("t5 ov nowb", ov2, 1);
        chk("t5 wb nowb", wb2, 0);
        chk("t5 hz nowb", hz2, 0);
        flush = 1;
        tick;
        flush = 0;

        // 6: reset mid-stream, STAGES=2
        wb_in = 1; mw_in = 1; dest_in = 4'd9; src1 = 4'd9;
        in_valid = 1; alu_in = 32'h50; rm_in = 32'h5555;
        tick;
        alu_in = 32'h51;
        tick;
        chk("t6 occ pre", occ2, 2);
        rst = 1; flush = 1;
        tick;
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        mw_in = 0; wb_in = 0; #1;
        chk("t6 ov", ov2, 0);   chk("t6 mw", mw2, 0);
        chk("t6 wb", wb2, 0);   chk("t6 alu", alu2, 0);
        chk("t6 rm", rm2, 0);   chk("t6 d", d2, 0);
        chk("t6 occ", occ2, 0); chk("t6 hz", hz2, 0);
        chk("t6 occ3", occ3, 0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("t6 no reappear", ov2, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
